// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for an asynchronous FIFO.
// Produces the RAM write strobe/address, the Gray write pointer and full/level/overflow status.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic                  wovf_clr,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam logic [ADDR_WIDTH:0]   PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH+1:0] AFULL_L = AFULL_THRESH[ADDR_WIDTH+1:0];

  function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_WIDTH:0] wbin_q, wbin_d;
  logic [ADDR_WIDTH:0] wgray_q, wgray_d;
  logic [ADDR_WIDTH:0] wlevel_q, wlevel_d;
  logic [ADDR_WIDTH:0] rbin_s;
  logic                wfull_q, wfull_d;
  logic                wafull_q, wafull_d;
  logic                wovf_q, wovf_d;
  logic                accept_s;

  // Next-state: pointer advance, full/level from the synchronised read pointer, sticky overflow.
  always_comb begin
    accept_s = winc & ~wfull_q & ~w_rst;
    wbin_d   = wbin_q;
    if (accept_s) begin
      wbin_d = wbin_q + PTR_ONE;
    end else begin
      wbin_d = wbin_q;
    end
    wgray_d  = bin2gray(wbin_d);
    rbin_s   = gray2bin(wq2_rptr);
    wfull_d  = (wgray_d == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]});
    wlevel_d = wbin_d - rbin_s;
    wafull_d = ({1'b0, wlevel_d} >= AFULL_L);
    // Set has priority over clear so a rejected write is never lost.
    wovf_d   = wovf_q;
    if (winc & wfull_q) begin
      wovf_d = 1'b1;
    end else if (wovf_clr) begin
      wovf_d = 1'b0;
    end else begin
      wovf_d = wovf_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign wclken       = accept_s;
  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr         = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = wovf_q;

endmodule
